mux_tree_pipe: RTL and testbench

- Parametrised N:1 word multiplexer built as a binary tree of 2:1 stages, the same structure as cascaded MUXF7/MUXF8 slices.
- Optional pipeline registers are inserted every LEVELS_PER_STAGE tree levels.
- A valid/ready handshake with backpressure wraps the pipeline.
- Used wherever the design needs a wide, deep select (register readback, channel selection) that must close timing at fabric clock rates.

---
 rtl/mux_tree_pipe.sv | 118 +++++++++++
 tb/tb_mux_tree_pipe.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_tree_pipe.sv
// N:1 word multiplexer built as a binary tree of 2:1 levels.
// Optional pipeline registers sit inside the tree, and a valid/ready handshake wraps it.
module mux_tree_pipe #(
  parameter  int unsigned WIDTH            = 8,
  parameter  int unsigned NUM_IN           = 8,
  parameter  int unsigned LEVELS_PER_STAGE = 2,
  localparam int unsigned SEL_W            = $clog2(NUM_IN)
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic [NUM_IN*WIDTH-1:0] I,
  input  logic [SEL_W-1:0]        S,
  input  logic                    IVLD,
  output logic                    IRDY,
  output logic [WIDTH-1:0]        O,
  output logic                    OVLD,
  input  logic                    ORDY,
  output logic                    OERR
);

  localparam int unsigned D       = SEL_W;
  localparam int unsigned NP      = 1 << D;
  localparam int unsigned TW      = NP * WIDTH;
  localparam int unsigned LPS_DIV = (LEVELS_PER_STAGE == 0) ? 1 : LEVELS_PER_STAGE;

  logic          ce;
  logic [TW-1:0] leaves;
  logic          err_in;

  // Missing leaves are zero, so out-of-range selects produce a zero word.
  assign leaves = TW'(I);
  assign err_in = 32'(S) >= NUM_IN;

  for (genvar j = 0; j < D; j++) begin : g_lvl
    localparam int unsigned NW      = NP >> j;
    localparam int unsigned SW      = D - j;
    localparam bit          HAS_REG = (LEVELS_PER_STAGE != 0) &&
                                      ((((j + 1) % LPS_DIV) == 0) || (j == D - 1));

    logic [NW*WIDTH-1:0]       d_in;
    logic [(NW/2)*WIDTH-1:0]   m_data;
    logic [(NW/2)*WIDTH-1:0]   d_out;
    logic [SW-1:0]             s_in;
    logic                      v_in;
    logic                      e_in;
    logic                      v_out;
    logic                      e_out;

    if (j == 0) begin : g_head
      assign d_in = leaves;
      assign s_in = S;
      assign v_in = IVLD;
      assign e_in = err_in;
    end else begin : g_link
      assign d_in = g_lvl[j-1].d_out;
      assign s_in = g_lvl[j-1].g_sel.s_out;
      assign v_in = g_lvl[j-1].v_out;
      assign e_in = g_lvl[j-1].e_out;
    end

    // One 2:1 level, steered by the lowest select bit still in flight.
    always_comb begin
      m_data = '0;
      for (int unsigned k = 0; k < NW / 2; k++) begin
        m_data[k*WIDTH +: WIDTH] = s_in[0] ? d_in[(2*k+1)*WIDTH +: WIDTH]
                                           : d_in[(2*k)*WIDTH +: WIDTH];
      end
    end

    // Select bits not yet consumed travel with their partial words.
    if (SW > 1) begin : g_sel
      logic [SW-2:0] s_out;
      if (HAS_REG) begin : g_q
        always_ff @(posedge CLK or negedge RSTN) begin
          if (!RSTN) begin
            s_out <= '0;
          end else if (ce) begin
            s_out <= s_in[SW-1:1];
          end
        end
      end else begin : g_c
        assign s_out = s_in[SW-1:1];
      end
    end

    if (HAS_REG) begin : g_q
      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          d_out <= '0;
          v_out <= 1'b0;
          e_out <= 1'b0;
        end else if (ce) begin
          d_out <= m_data;
          v_out <= v_in;
          e_out <= e_in;
        end
      end
    end else begin : g_c
      assign d_out = m_data;
      assign v_out = v_in;
      assign e_out = e_in;
    end
  end

  assign O    = g_lvl[D-1].d_out;
  assign OVLD = g_lvl[D-1].v_out;
  assign OERR = g_lvl[D-1].e_out;

  // Every stage shares one enable; bubbles are kept so the pipe never collapses.
  if (LEVELS_PER_STAGE == 0) begin : g_comb
    assign ce   = 1'b1;
    assign IRDY = ORDY;
  end else begin : g_flow
    assign ce   = ORDY || !OVLD;
    assign IRDY = ce;
  end

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed bench for mux_tree_pipe: pipelined (L=2, L=3) and combinational configurations.
module tb_mux_tree_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // A: 8 x 8-bit, two levels per stage (L=2)
  logic [63:0] a_i;
  logic [2:0]  a_s;
  logic        a_ivld, a_irdy, a_ovld, a_ordy, a_oerr;
  logic [7:0]  a_o;
  // B: 6 x 8-bit, one level per stage (L=3)
  logic [47:0] b_i;
  logic [2:0]  b_s;
  logic        b_ivld, b_irdy, b_ovld, b_ordy, b_oerr;
  logic [7:0]  b_o;
  // C: 5 x 16-bit, combinational
  logic [79:0] c_i;
  logic [2:0]  c_s;
  logic        c_ivld, c_irdy, c_ovld, c_ordy, c_oerr;
  logic [15:0] c_o;

  int n_cmp = 0;
  int n_bad = 0;

  mux_tree_pipe #(.WIDTH(8), .NUM_IN(8), .LEVELS_PER_STAGE(2)) u_a (
    .CLK(clk), .RSTN(rst_n), .I(a_i), .S(a_s), .IVLD(a_ivld), .IRDY(a_irdy),
    .O(a_o), .OVLD(a_ovld), .ORDY(a_ordy), .OERR(a_oerr));

  mux_tree_pipe #(.WIDTH(8), .NUM_IN(6), .LEVELS_PER_STAGE(1)) u_b (
    .CLK(clk), .RSTN(rst_n), .I(b_i), .S(b_s), .IVLD(b_ivld), .IRDY(b_irdy),
    .O(b_o), .OVLD(b_ovld), .ORDY(b_ordy), .OERR(b_oerr));

  mux_tree_pipe #(.WIDTH(16), .NUM_IN(5), .LEVELS_PER_STAGE(0)) u_c (
    .CLK(clk), .RSTN(rst_n), .I(c_i), .S(c_s), .IVLD(c_ivld), .IRDY(c_irdy),
    .O(c_o), .OVLD(c_ovld), .ORDY(c_ordy), .OERR(c_oerr));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not finish, got 0 expected 1");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          acc;
    int          got;
    logic        exp_v;
    logic [2:0]  bs_tab [4];
    logic [7:0]  bo_tab [4];
    logic        be_tab [4];

    bs_tab = '{3'd7, 3'd5, 3'd6, 3'd0};
    bo_tab = '{8'h00, 8'hA5, 8'h00, 8'h20};
    be_tab = '{1'b1, 1'b0, 1'b1, 1'b0};

    rst_n  = 1'b0;
    a_ivld = 1'b0; a_ordy = 1'b1; a_s = '0;
    b_ivld = 1'b0; b_ordy = 1'b1; b_s = '0;
    c_ivld = 1'b0; c_ordy = 1'b1; c_s = '0;
    for (int k = 0; k < 8; k++) a_i[k*8 +: 8] = 8'h10 + 8'(k);
    for (int k = 0; k < 6; k++) b_i[k*8 +: 8] = 8'h20 + 8'(k);
    b_i[5*8 +: 8] = 8'hA5;
    for (int k = 0; k < 5; k++) c_i[k*16 +: 16] = 16'h1000 + 16'(k);
    c_i[3*16 +: 16] = 16'hBEEF;

    // Reset state
    #12;
    check("rst_ovld", a_ovld, 0);
    check("rst_o", a_o, 0);
    check("rst_oerr", a_oerr, 0);
    check("rst_irdy", a_irdy, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Sweep S=0..7 back-to-back, two-cycle latency
    for (int n = 1; n <= 10; n++) begin
      a_ivld = (n <= 8);
      a_s    = 3'(n - 1);
      tick();
      exp_v = (n >= 2 && n <= 9);
      check("sweep_ovld", a_ovld, exp_v);
      if (exp_v) begin
        check("sweep_o", a_o, 8'h10 + 8'(n - 2));
        check("sweep_oerr", a_oerr, 0);
      end
    end

    // Backpressure: ORDY low for three edges, S scrambled while stalled
    acc = 0;
    got = 0;
    for (int n = 1; n <= 24 && got < 8; n++) begin
      a_ordy = !(n >= 5 && n <= 7);
      #1;
      a_ivld = (acc < 8);
      a_s    = a_irdy ? 3'(acc) : ~3'(acc);
      if (n >= 5 && n <= 7) begin
        check("stall_irdy", a_irdy, 0);
        check("stall_ovld", a_ovld, 1);
        check("stall_o", a_o, 8'h12);
      end
      if (a_ovld && a_ordy) begin
        check("stream_o", a_o, 8'h10 + 8'(got));
        check("stream_oerr", a_oerr, 0);
        got++;
      end
      if (a_ivld && a_irdy) acc++;
      tick();
    end
    check("stream_count", got, 8);
    a_ivld = 1'b0;
    a_ordy = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("stream_tail_ovld", a_ovld, 0);
    end

    // Bubbles preserved: IVLD 1,0,1,0
    for (int n = 1; n <= 6; n++) begin
      a_ivld = (n == 1 || n == 3);
      a_s    = (n == 1) ? 3'd1 : ((n == 3) ? 3'd2 : 3'd0);
      tick();
      exp_v = (n == 2 || n == 4);
      check("bubble_ovld", a_ovld, exp_v);
      if (exp_v) check("bubble_o", a_o, (n == 2) ? 8'h11 : 8'h12);
    end

    // NUM_IN=6, L=3: out-of-range and in-range selects
    for (int n = 1; n <= 7; n++) begin
      b_ivld = (n <= 4);
      b_s    = (n <= 4) ? bs_tab[n-1] : 3'd0;
      tick();
      exp_v = (n >= 3 && n <= 6);
      check("b_ovld", b_ovld, exp_v);
      if (exp_v) begin
        check("b_o", b_o, bo_tab[n-3]);
        check("b_oerr", b_oerr, be_tab[n-3]);
      end
    end
    b_ivld = 1'b0;

    // Mid-operation reset discards in-flight beats
    a_ivld = 1'b1; a_s = 3'd4;
    tick();
    a_s = 3'd5;
    tick();
    check("pre_rst_ovld", a_ovld, 1);
    check("pre_rst_o", a_o, 8'h14);
    a_ivld = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ovld", a_ovld, 0);
    check("mid_rst_o", a_o, 0);
    check("mid_rst_irdy", a_irdy, 1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      check("post_rst_ovld", a_ovld, 0);
    end

    // Combinational configuration
    c_s = 3'd3; c_ivld = 1'b1; c_ordy = 1'b1;
    #1;
    check("c_o3", c_o, 16'hBEEF);
    check("c_ovld1", c_ovld, 1);
    check("c_irdy1", c_irdy, 1);
    check("c_oerr3", c_oerr, 0);
    c_ivld = 1'b0; c_ordy = 1'b0;
    #1;
    check("c_ovld0", c_ovld, 0);
    check("c_irdy0", c_irdy, 0);
    c_ordy = 1'b1;
    #1;
    check("c_irdy_follow", c_irdy, 1);
    c_s = 3'd4;
    #1;
    check("c_o4", c_o, 16'h1004);
    check("c_oerr4", c_oerr, 0);
    c_s = 3'd5;
    #1;
    check("c_o5", c_o, 16'h0000);
    check("c_oerr5", c_oerr, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
